// File: rtl/flash_spi_reader_pkg.sv
// Shared constants, state type and helpers for the SPI NOR word reader.
// Build option: FLASH_FASTREAD_EN selects FAST_READ (0x0B) with 8 dummy bits;
// without it the reader issues plain READ (0x03) with no dummy phase.
package flash_pkg;

   localparam logic [7:0] CMD_READ      = 8'h03;
   localparam logic [7:0] CMD_FAST_READ = 8'h0B;

   localparam int CMD_BITS   = 8;
   localparam int ADDR_BITS  = 24;
   localparam int DUMMY_BITS = 8;
   localparam int DATA_BITS  = 32;

`ifdef FLASH_FASTREAD_EN
   localparam logic [7:0] CMD_OPCODE = CMD_FAST_READ;
   localparam int FRAME_BITS = CMD_BITS + ADDR_BITS + DUMMY_BITS + DATA_BITS;
`else
   localparam logic [7:0] CMD_OPCODE = CMD_READ;
   localparam int FRAME_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Bytes arrive first-byte-in-MSB; the returned word is little-endian.
   function automatic logic [31:0] swap_bytes(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/flash_spi_reader_sck_gen.sv
// SCK prescaler: CLK_DIV-cycle half periods, idle low, restarted on accept.
// rise_tick/fall_tick flag the clk edge on which flash_sck will rise/fall.
module flash_sck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic nreset,
   input  logic en,
   input  logic restart,
   output logic flash_sck,
   output logic rise_tick,
   output logic fall_tick
);

   localparam logic [7:0] LOAD = 8'(CLK_DIV - 1);

   logic [7:0] cnt;
   logic       terminal;

   assign terminal  = (cnt == 8'd0);
   assign rise_tick = en && terminal && !flash_sck;
   assign fall_tick = en && terminal &&  flash_sck;

   // Half-period down-counter; toggles sck at terminal count while enabled.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cnt       <= 8'd0;
         flash_sck <= 1'b0;
      end else if (restart) begin
         cnt       <= LOAD;
         flash_sck <= 1'b0;
      end else if (en) begin
         if (terminal) begin
            cnt       <= LOAD;
            flash_sck <= ~flash_sck;
         end else begin
            cnt <= cnt - 8'd1;
         end
      end else begin
         cnt       <= LOAD;
         flash_sck <= 1'b0;
      end
   end

endmodule

// File: rtl/flash_spi_reader.sv
// SPI NOR word reader: one 24-bit address in, one little-endian 32-bit word out.
// Mode 0, MSB first. Build option FLASH_FASTREAD_EN switches to FAST_READ
// with an 8-bit dummy phase (frame 72 bits instead of 64).
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | req_ready high, cs high, waiting for req_valid
//   SHIFT | cs low, clocking cmd/addr(/dummy) out and data in
//   GAP   | cs high for CS_GAP cycles before the next frame may start
module flash_spi_reader
   import flash_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int ADDR_W  = 24,
   parameter int CS_GAP  = 4
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   output logic [31:0]       rsp_data,
   output logic              flash_sck,
   output logic              flash_cs,
   output logic              flash_mosi,
   input  logic              flash_miso
);

   localparam int BIT_CNT_W = $clog2(FRAME_BITS);
   localparam int GAP_W     = $clog2(CS_GAP + 1);

   state_t                 state, nstate;
   logic                   accept, done, gap_end, shift_en;
   logic                   rise_tick, fall_tick;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic [GAP_W-1:0]       gap_cnt;
   logic [FRAME_BITS-1:0]  tx_sr, frame;
   logic [DATA_BITS-1:0]   rx_sr;
   logic [ADDR_BITS-1:0]   addr_field;

   assign accept   = req_valid && req_ready;
   assign shift_en = (state == SHIFT);
   assign done     = shift_en && fall_tick && (bit_cnt == '0);
   assign gap_end  = (state == GAP) && (gap_cnt == '0);

   assign addr_field = ADDR_BITS'(req_addr);
`ifdef FLASH_FASTREAD_EN
   assign frame = {CMD_OPCODE, addr_field, {DUMMY_BITS{1'b0}}, {DATA_BITS{1'b0}}};
`else
   assign frame = {CMD_OPCODE, addr_field, {DATA_BITS{1'b0}}};
`endif

   assign flash_mosi = tx_sr[FRAME_BITS-1];

   flash_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
      .clk       (clk),
      .nreset    (nreset),
      .en        (shift_en),
      .restart   (accept),
      .flash_sck (flash_sck),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

   // State register.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) state <= IDLE;
      else         state <= nstate;
   end

   // Next-state decode.
   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (accept)  nstate = SHIFT;
         SHIFT:   if (done)    nstate = GAP;
         GAP:     if (gap_end) nstate = IDLE;
         default:              nstate = IDLE;
      endcase
   end

   // Handshake, chip select and the bit / gap terminal-count timers.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         req_ready <= 1'b0;
         flash_cs  <= 1'b1;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
      end else begin
         req_ready <= (nstate == IDLE);
         if (accept) begin
            flash_cs <= 1'b0;
            bit_cnt  <= BIT_CNT_W'(FRAME_BITS - 1);
         end else if (done) begin
            flash_cs <= 1'b1;
            gap_cnt  <= GAP_W'(CS_GAP - 1);
         end else if (shift_en && fall_tick) begin
            bit_cnt <= bit_cnt - 1'b1;
         end else if (state == GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end

   // Transmit shifter; the data field is zero so mosi idles low there.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)                           tx_sr <= '0;
      else if (accept)                       tx_sr <= frame;
      else if (shift_en && fall_tick && !done) tx_sr <= tx_sr << 1;
   end

   // Receive shifter; after the last rise it holds exactly the data bits.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)                     rx_sr <= '0;
      else if (shift_en && rise_tick)  rx_sr <= {rx_sr[DATA_BITS-2:0], flash_miso};
   end

   // Response word and one-cycle valid strobe on the final sck fall.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= done;
         if (done) rsp_data <= swap_bytes(rx_sr);
      end
   end

endmodule
